// File: rtl/f_predpc_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator.
package f_predpc_pkg;

   localparam int unsigned PC_W = 13;

   typedef logic [PC_W-1:0] pc_t;

   localparam pc_t RESET_PC_DEFAULT = 13'h0000;

   // 2-bit saturating branch counter encodings
   typedef enum logic [1:0] {
      CtrSnt = 2'b00,
      CtrWnt = 2'b01,
      CtrWt  = 2'b10,
      CtrSt  = 2'b11
   } ctr_e;

   // Saturating counter step toward the resolved outcome
   function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
      ctr_e res;
      res = ctr;
      unique case (ctr)
         CtrSnt: res = taken ? CtrWnt : CtrSnt;
         CtrWnt: res = taken ? CtrWt  : CtrSnt;
         CtrWt:  res = taken ? CtrSt  : CtrWnt;
         CtrSt:  res = taken ? CtrSt  : CtrWt;
         default: res = ctr;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/f_predpc_if.sv
// Fetch control / BTB training / prediction bundle between the pipeline and f_predpc.
interface f_predpc_if;
   import f_predpc_pkg::*;

   logic stall;
   logic redirect;
   pc_t  redirect_pc;
   logic upd_valid;
   pc_t  upd_pc;
   pc_t  upd_target;
   logic upd_taken;
   logic upd_uncond;
   pc_t  pc1;
   pc_t  pc2;
   pc_t  pc_predicted;
   logic pred_taken;
   logic inst_number;

   // Pipeline side: drives control and training, consumes fetch addresses
   modport master (
      output stall, redirect, redirect_pc,
      output upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
      input  pc1, pc2, pc_predicted, pred_taken, inst_number
   );

   // Predictor side
   modport slave (
      input  stall, redirect, redirect_pc,
      input  upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
      output pc1, pc2, pc_predicted, pred_taken, inst_number
   );

endinterface

// File: rtl/f_btb.sv
// Direct-mapped branch target buffer: two combinational read ports, one training write port.
module f_btb
   import f_predpc_pkg::*;
#(
   parameter int unsigned ENTRIES = 64
) (
   input  logic clk,
   input  logic rst,
   input  pc_t  rd0_pc,
   input  pc_t  rd1_pc,
   output logic rd0_taken,
   output pc_t  rd0_target,
   output logic rd1_taken,
   output pc_t  rd1_target,
   input  logic upd_valid,
   input  pc_t  upd_pc,
   input  pc_t  upd_target,
   input  logic upd_taken,
   input  logic upd_uncond
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_W - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   pc_t              target_q [ENTRIES];
   ctr_e             ctr_q    [ENTRIES];
   logic             uncond_q [ENTRIES];

   logic [IDX_W-1:0] rd0_idx, rd1_idx, wr_idx;
   logic [TAG_W-1:0] rd0_tag, rd1_tag, wr_tag;
   logic             rd0_hit, rd1_hit, upd_hit;
   logic             wr_en;
   pc_t              wr_target;
   ctr_e             wr_ctr;
   logic             wr_uncond;

   // Lookup for both fetch slots; reads the array state before any same-cycle write
   always_comb begin
      rd0_idx    = rd0_pc[IDX_W-1:0];
      rd0_tag    = rd0_pc[PC_W-1:IDX_W];
      rd1_idx    = rd1_pc[IDX_W-1:0];
      rd1_tag    = rd1_pc[PC_W-1:IDX_W];
      rd0_hit    = valid_q[rd0_idx] && (tag_q[rd0_idx] == rd0_tag);
      rd1_hit    = valid_q[rd1_idx] && (tag_q[rd1_idx] == rd1_tag);
      rd0_taken  = rd0_hit && (uncond_q[rd0_idx] || ctr_q[rd0_idx][1]);
      rd1_taken  = rd1_hit && (uncond_q[rd1_idx] || ctr_q[rd1_idx][1]);
      rd0_target = target_q[rd0_idx];
      rd1_target = target_q[rd1_idx];
   end

   // Training: update on hit, allocate only on a taken miss
   always_comb begin
      wr_idx    = upd_pc[IDX_W-1:0];
      wr_tag    = upd_pc[PC_W-1:IDX_W];
      upd_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
      wr_en     = 1'b0;
      wr_target = target_q[wr_idx];
      wr_ctr    = ctr_q[wr_idx];
      wr_uncond = uncond_q[wr_idx];
      if (upd_valid) begin
         if (upd_hit) begin
            wr_en     = 1'b1;
            wr_target = upd_taken ? upd_target : target_q[wr_idx];
            wr_ctr    = ctr_next(ctr_q[wr_idx], upd_taken);
            wr_uncond = upd_uncond;
         end else if (upd_taken) begin
            wr_en     = 1'b1;
            wr_target = upd_target;
            wr_ctr    = upd_uncond ? CtrSt : CtrWt;
            wr_uncond = upd_uncond;
         end
      end
   end

   // Storage array; reset clears every entry so no stale prediction survives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CtrSnt;
            uncond_q[i] <= 1'b0;
         end
      end else if (wr_en) begin
         valid_q[wr_idx]  <= 1'b1;
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
         ctr_q[wr_idx]    <= wr_ctr;
         uncond_q[wr_idx] <= wr_uncond;
      end
   end

endmodule

// File: rtl/f_predpc.sv
// Fetch PC register, two-slot prediction priority and next-PC selection.
module f_predpc
   import f_predpc_pkg::*;
#(
   parameter int unsigned ENTRIES  = 64,
   parameter pc_t         RESET_PC = RESET_PC_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   f_predpc_if.slave  bus
);

   pc_t  pc_q, pc_d;
   pc_t  pc_next_slot;
   logic slot0_taken, slot1_taken;
   pc_t  slot0_target, slot1_target;

   assign pc_next_slot = pc_q + pc_t'(1);

   f_btb #(
      .ENTRIES (ENTRIES)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .rd0_pc     (pc_q),
      .rd1_pc     (pc_next_slot),
      .rd0_taken  (slot0_taken),
      .rd0_target (slot0_target),
      .rd1_taken  (slot1_taken),
      .rd1_target (slot1_target),
      .upd_valid  (bus.upd_valid),
      .upd_pc     (bus.upd_pc),
      .upd_target (bus.upd_target),
      .upd_taken  (bus.upd_taken),
      .upd_uncond (bus.upd_uncond)
   );

   // Slot 0 wins; a taken slot 0 makes slot 1 irrelevant
   always_comb begin
      bus.pc1          = pc_q;
      bus.pc2          = pc_next_slot;
      bus.pred_taken   = 1'b0;
      bus.inst_number  = 1'b0;
      bus.pc_predicted = pc_q + pc_t'(2);
      if (slot0_taken) begin
         bus.pred_taken   = 1'b1;
         bus.pc_predicted = slot0_target;
      end else if (slot1_taken) begin
         bus.pred_taken   = 1'b1;
         bus.inst_number  = 1'b1;
         bus.pc_predicted = slot1_target;
      end
   end

   // Next PC: redirect beats stall, stall beats prediction
   always_comb begin
      pc_d = pc_q;
      if (bus.redirect) begin
         pc_d = bus.redirect_pc;
      end else if (!bus.stall) begin
         pc_d = bus.pc_predicted;
      end
   end

   // Fetch PC register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_f_predpc.sv
// Directed bench for f_predpc: reset, allocation, slot priority, counters, redirect/stall, wrap.
module tb_f_predpc;
   import f_predpc_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   f_predpc_if bus ();

   f_predpc #(
      .ENTRIES  (64),
      .RESET_PC (13'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Force the fetch PC via redirect (works while stalled)
   task automatic set_pc(input pc_t p);
      bus.redirect    = 1'b1;
      bus.redirect_pc = p;
      @(posedge clk);
      #1;
      bus.redirect    = 1'b0;
   endtask

   // One-cycle training pulse
   task automatic train(input pc_t p, input pc_t t, input logic tk, input logic un);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = p;
      bus.upd_target = t;
      bus.upd_taken  = tk;
      bus.upd_uncond = un;
      @(posedge clk);
      #1;
      bus.upd_valid  = 1'b0;
   endtask

   task automatic check_pred(input string tag, input logic tk, input logic num, input pc_t pp);
      check({tag, "_taken"}, 32'(bus.pred_taken), 32'(tk));
      check({tag, "_num"},   32'(bus.inst_number), 32'(num));
      check({tag, "_pcp"},   32'(bus.pc_predicted), 32'(pp));
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst             = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.upd_valid   = 1'b0;
      bus.upd_pc      = '0;
      bus.upd_target  = '0;
      bus.upd_taken   = 1'b0;
      bus.upd_uncond  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc1", 32'(bus.pc1), 32'h0);
      check("rst_pc2", 32'(bus.pc2), 32'h1);
      check_pred("rst", 1'b0, 1'b0, 13'h2);
      @(negedge clk);
      rst = 1'b0;

      // Sequential fetch 0,2,4
      @(posedge clk); #1;
      check("seq_pc1_a", 32'(bus.pc1), 32'h2);
      @(posedge clk); #1;
      check("seq_pc1_b", 32'(bus.pc1), 32'h4);
      check("seq_pcp_b", 32'(bus.pc_predicted), 32'h6);

      // Asynchronous reset mid-cycle takes effect immediately
      #2 rst = 1'b1;
      #1;
      check("arst_pc1", 32'(bus.pc1), 32'h0);
      check("arst_pc2", 32'(bus.pc2), 32'h1);
      check_pred("arst", 1'b0, 1'b0, 13'h2);
      #1 rst = 1'b0;
      bus.stall = 1'b1;

      // Update in flight across a reset edge is discarded
      @(posedge clk); #1;
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 13'h030;
      bus.upd_target = 13'h0C0;
      bus.upd_taken  = 1'b1;
      bus.upd_uncond = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      bus.upd_valid = 1'b0;
      rst = 1'b0;
      set_pc(13'h030);
      check("rst_discard", 32'(bus.pred_taken), 32'h0);

      // Allocation
      train(13'h010, 13'h040, 1'b1, 1'b0);
      set_pc(13'h010);
      check_pred("alloc", 1'b1, 1'b0, 13'h040);

      // No bypass: same-cycle update invisible until the edge
      set_pc(13'h060);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 13'h060;
      bus.upd_target = 13'h123;
      bus.upd_taken  = 1'b1;
      bus.upd_uncond = 1'b0;
      @(negedge clk);
      check("nobyp_old", 32'(bus.pred_taken), 32'h0);
      @(posedge clk); #1;
      bus.upd_valid = 1'b0;
      check_pred("nobyp_new", 1'b1, 1'b0, 13'h123);

      // Slot 1 prediction, then slot 0 wins
      train(13'h021, 13'h100, 1'b1, 1'b0);
      set_pc(13'h020);
      check_pred("slot1", 1'b1, 1'b1, 13'h100);
      train(13'h020, 13'h0A0, 1'b1, 1'b0);
      check_pred("slot0_wins", 1'b1, 1'b0, 13'h0A0);

      // Counter walk at 0x010 (ctr starts at WT)
      set_pc(13'h010);
      train(13'h010, 13'h055, 1'b0, 1'b0);   // ctr 1
      check("ctr_nt1", 32'(bus.pred_taken), 32'h0);
      train(13'h010, 13'h055, 1'b0, 1'b0);   // ctr 0
      check("ctr_nt2", 32'(bus.pred_taken), 32'h0);
      train(13'h010, 13'h055, 1'b0, 1'b0);   // stays 0
      train(13'h010, 13'h040, 1'b1, 1'b0);   // ctr 1
      check("ctr_t1", 32'(bus.pred_taken), 32'h0);
      train(13'h010, 13'h040, 1'b1, 1'b0);   // ctr 2
      check_pred("ctr_t2", 1'b1, 1'b0, 13'h040);
      train(13'h010, 13'h040, 1'b1, 1'b0);   // ctr 3
      train(13'h010, 13'h040, 1'b1, 1'b0);   // stays 3
      check("ctr_sat", 32'(bus.pred_taken), 32'h1);
      train(13'h010, 13'h055, 1'b0, 1'b0);   // ctr 2
      check_pred("ctr_st_nt", 1'b1, 1'b0, 13'h040);
      train(13'h010, 13'h055, 1'b0, 1'b0);   // ctr 1
      check("ctr_wnt", 32'(bus.pred_taken), 32'h0);

      // Unconditional entry predicts taken whatever the counter
      train(13'h070, 13'h155, 1'b1, 1'b1);
      repeat (4) train(13'h070, 13'h000, 1'b0, 1'b1);
      set_pc(13'h070);
      check_pred("uncond", 1'b1, 1'b0, 13'h155);

      // Redirect overrides stall; stall holds
      set_pc(13'h1F00);
      check("redir_pc1", 32'(bus.pc1), 32'h1F00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("stall_hold%0d", i), 32'(bus.pc1), 32'h1F00);
      end
      bus.stall = 1'b0;
      @(posedge clk); #1;
      check("unstall_pc1", 32'(bus.pc1), 32'h1F02);
      bus.stall = 1'b1;

      // PC wrap
      set_pc(13'h1FFF);
      check("wrap_pc2", 32'(bus.pc2), 32'h0);
      check_pred("wrap", 1'b0, 1'b0, 13'h0001);

      // Aliasing: same index, different tag misses
      train(13'h050, 13'h0AA, 1'b1, 1'b0);
      set_pc(13'h050);
      check_pred("alias_hit", 1'b1, 1'b0, 13'h0AA);
      set_pc(13'h090);
      check_pred("alias_miss", 1'b0, 1'b0, 13'h092);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/f_predpc.md
# f_predpc

Fetch-stage next-PC generator and branch predictor for the dual-issue RV32I pipeline. Holds the fetch PC, looks up a direct-mapped branch target buffer (BTB) with 2-bit counters for both fetch slots, and produces the predicted next fetch PC carried down the pipe as `pc_predicted`. It accepts misprediction redirects and training updates from the D-stage (jal) and E-stage (branch/jalr) PC-calculation blocks, which compute `true_pc` and `fail_predict`.

## Interface
- `ENTRIES`, 64: BTB entries; power of two, 4..256.
- `RESET_PC`, 13'h0000: fetch word address after reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold fetch PC, no prediction advance.
- `redirect`  in  1: misprediction flush; load `redirect_pc`.
- `redirect_pc`  in  13: corrected word address (`true_pc` from D or E).
- `upd_valid`  in  1: train BTB this cycle.
- `upd_pc`  in  13: word address of the resolved control-transfer instruction.
- `upd_target`  in  13: resolved target word address.
- `upd_taken`  in  1: resolved outcome.
- `upd_uncond`  in  1: jal/jalr (always taken).
- `pc1`  out  13: slot-0 fetch word address (current PC).
- `pc2`  out  13: slot-1 fetch word address, `pc1 + 1`, wraps mod 2^13.
- `pc_predicted`  out  13: predicted next fetch PC for this fetch pair.
- `pred_taken`  out  1: a slot was predicted taken.
- `inst_number`  out  1: 0 = slot 0 predicted taken, 1 = slot 1 (0 when `pred_taken` = 0).

## Operation
- BTB entry: valid, tag `pc[12:log2(ENTRIES)]`, target[12:0], ctr[1:0], uncond. Index `pc[log2(ENTRIES)-1:0]`.
- Lookup (combinational, both slots): hit = valid & tag match. Slot predicted taken if hit and (uncond or ctr[1]).
- Priority: slot 0 taken -> `pc_predicted` = slot-0 target, `inst_number` = 0, slot 1 discarded. Else slot 1 taken -> slot-1 target, `inst_number` = 1. Else `pc_predicted` = `pc1 + 2` (13-bit wrap), `pred_taken` = 0.
- PC register next value, priority: `redirect` -> `redirect_pc`; else `stall` -> hold; else `pc_predicted`. `redirect` overrides `stall`.
- Training when `upd_valid`:
  - Miss (invalid or tag mismatch): allocate only if `upd_taken`; write valid, tag, target, uncond, ctr = 2'b10 (uncond: 2'b11). Not-taken miss: no write.
  - Hit: target <= `upd_target` if `upd_taken`; uncond <= `upd_uncond`; ctr saturating: taken -> min(ctr+1, 3), not-taken -> max(ctr-1, 0).
- Training is independent of `stall` and `redirect`.
- No entry is ever invalidated except by reset.

## Timing
- Reset (async): PC = `RESET_PC`; all valid bits = 0; so `pc1` = `RESET_PC`, `pc2` = `RESET_PC+1`, `pred_taken` = 0, `inst_number` = 0, `pc_predicted` = `RESET_PC+2`. Reset mid-operation discards in-flight updates.
- Lookup: zero latency from PC register; outputs valid same cycle.
- Redirect: `pc1` = `redirect_pc` on the cycle after `redirect`; one-cycle bubble is the caller's responsibility.
- Update visibility: BTB write lands at clock edge; a lookup in the same cycle as an update to the same index sees the old contents (no bypass). Visible next cycle.
- Counter and target updated by at most one port per cycle; D and E arbitration is outside this block (E has priority).

## Structure
- Shared package/define file: `RESET_PC` default, counter encodings (SNT=0, WNT=1, WT=2, ST=3), 13-bit PC width constant.
- One natural sub-module `f_btb`: storage array, two read ports, one write port with counter update logic. `f_predpc` holds PC register, slot priority and next-PC mux.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `pc1`=0, `pc2`=1, `pc_predicted`=2, `pred_taken`=0 immediately; sequential fetch 0,2,4,...
- Allocation: update pc=13'h010, target=13'h040, taken, cond -> next visit to pc1=13'h010 gives `pred_taken`=1, `inst_number`=0, `pc_predicted`=13'h040.
- Slot 1: entry at 13'h021 -> target 13'h100; fetch pc1=13'h020 -> `inst_number`=1, `pc_predicted`=13'h100; add taken entry at 13'h020 -> slot 0 wins.
- Counter: from ctr=2, two not-taken updates -> ctr=0, `pred_taken`=0 at that PC; three taken updates -> ctr=3, saturates; uncond entry predicts taken regardless.
- Redirect vs stall: `stall`=1 and `redirect`=1 with `redirect_pc`=13'h1F00 -> `pc1`=13'h1F00 next cycle; `stall` alone holds PC for 3 cycles.
- Wrap/aliasing: pc1=13'h1FFF -> `pc2`=0, `pc_predicted`=1; update at 13'h0050 and lookup of 13'h0090 (same index, ENTRIES=64, different tag) -> miss.
